// File: rtl/adder_rr_scheduler.sv
// Round-robin scheduler sharing one 8-bit parallel-prefix adder among NREQ requesters.
// Optional transaction counter enabled by defining ADDER_RR_SCHED_STATS_EN.

module adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] sum
);

  logic [6:0] g0;
  logic [7:0] p0;
  logic [6:0] g1;
  logic [6:2] p1;
  logic [6:0] g2;
  logic [6:4] p2;
  logic [6:0] g3;

  // Kogge-Stone prefix over bits 0..6; bit 7 carry-out is never formed
  always_comb begin
    g0  = a[6:0] & b[6:0];
    p0  = a ^ b;
    g1  = {g0[6:1] | (p0[6:1] & g0[5:0]), g0[0]};
    p1  = p0[6:2] & p0[5:1];
    g2  = {g1[6:2] | (p1[6:2] & g1[4:0]), g1[1:0]};
    p2  = p1[6:4] & p1[4:2];
    g3  = {g2[6:4] | (p2[6:4] & g2[2:0]), g2[3:0]};
    sum = p0 ^ {g3, 1'b0};
  end

endmodule

module adder_rr_scheduler #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*8-1:0]   req_a,
  input  logic [NREQ*8-1:0]   req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [7:0]          rsp_sum,
  output logic [15:0]         txn_count
);

  logic [7:0]     a_q, a_d, b_q, b_d;
  logic [IDW-1:0] id_q, id_d;
  logic           a_vld_q, a_vld_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [7:0]     rsp_sum_q, rsp_sum_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic           rsp_valid_q, rsp_valid_d;

  logic           r_load, a_free, accept, grant_found;
  logic [IDW-1:0] grant_id;
  logic [IDW:0]   cand;
  logic [7:0]     sel_a, sel_b, adder_sum;

  adder u_adder (
    .a   (a_q),
    .b   (b_q),
    .sum (adder_sum)
  );

  // Search starts just after the last winner and wraps modulo NREQ
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      if (!grant_found && req_valid[cand[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    r_load = a_vld_q & (~rsp_valid_q | rsp_ready);
    a_free = ~a_vld_q | r_load;
    accept = grant_found & a_free;

    req_ready = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id == IDW'(i)) begin
        req_ready[i] = accept;
        sel_a        = req_a[8*i +: 8];
        sel_b        = req_b[8*i +: 8];
      end
    end

    a_d     = accept ? sel_a : a_q;
    b_d     = accept ? sel_b : b_q;
    id_d    = accept ? grant_id : id_q;
    ptr_d   = accept ? grant_id : ptr_q;
    a_vld_d = accept | (a_vld_q & ~r_load);

    rsp_sum_d   = r_load ? adder_sum : rsp_sum_q;
    rsp_id_d    = r_load ? id_q : rsp_id_q;
    rsp_valid_d = r_load | (rsp_valid_q & ~rsp_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= '0;
      a_vld_q     <= 1'b0;
      ptr_q       <= IDW'(NREQ-1);
      rsp_sum_q   <= '0;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      a_vld_q     <= a_vld_d;
      ptr_q       <= ptr_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_id_q    <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;

`ifdef ADDER_RR_SCHED_STATS_EN
  logic [15:0] txn_q, txn_d;

  // Saturating count of accepted operand pairs
  always_comb begin
    txn_d = txn_q;
    if (accept && txn_q != 16'hFFFF) txn_d = txn_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) txn_q <= '0;
    else        txn_q <= txn_d;
  end

  assign txn_count = txn_q;
`else
  assign txn_count = 16'h0000;
`endif

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Directed bench for adder_rr_scheduler: table of single requests plus
// round-robin, backpressure, async reset and counter sequences.

module tb_adder_rr_scheduler;

  localparam int NREQ = 4;

  logic        clk = 1'b0;
  logic        rstN;
  logic [3:0]  reqValid;
  logic [3:0]  reqReady;
  logic [31:0] reqA, reqB;
  logic        rspValid;
  logic        rspReady;
  logic [1:0]  rspId;
  logic [7:0]  rspSum;
  logic [15:0] txnCount;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0] id;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
    logic [3:0] ready;
  } vec_t;

  vec_t        vecs[7];
  logic [7:0]  opA[4];
  logic [7:0]  opB[4];
  logic [31:0] allA, allB;
  int          rrSeq[8];

  adder_rr_scheduler #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rstN),
    .req_valid (reqValid),
    .req_ready (reqReady),
    .req_a     (reqA),
    .req_b     (reqB),
    .rsp_valid (rspValid),
    .rsp_ready (rspReady),
    .rsp_id    (rspId),
    .rsp_sum   (rspSum),
    .txn_count (txnCount)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic [31:0] a,
                               input logic [31:0] b, input logic rdy);
    reqValid = valid;
    reqA     = a;
    reqB     = b;
    rspReady = rdy;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Leaves the clock mid-cycle, a few ns after reset release
  task automatic doReset;
    rstN = 1'b0;
    applyStimulus(4'b0000, 32'h0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #3 rstN = 1'b1;
    #1;
  endtask

  function automatic logic [31:0] place(input int i, input logic [7:0] v);
    return 32'(v) << (8 * i);
  endfunction

  function automatic logic [7:0] expSum(input int i);
    return opA[i] + opB[i];
  endfunction

  initial begin
    vecs[0] = '{2'd2, 8'h5A, 8'h3C, 8'h96, 4'b0100};
    vecs[1] = '{2'd0, 8'hFF, 8'h01, 8'h00, 4'b0001};
    vecs[2] = '{2'd1, 8'h80, 8'h80, 8'h00, 4'b0010};
    vecs[3] = '{2'd3, 8'h12, 8'h34, 8'h46, 4'b1000};
    vecs[4] = '{2'd2, 8'hF0, 8'h0F, 8'hFF, 4'b0100};
    vecs[5] = '{2'd0, 8'h7F, 8'h01, 8'h80, 4'b0001};
    vecs[6] = '{2'd3, 8'hC8, 8'h64, 8'h2C, 4'b1000};
    rrSeq   = '{0, 1, 2, 3, 0, 1, 2, 3};
    for (int i = 0; i < 4; i++) begin
      opA[i] = 8'h31 + 8'(8'h40 * i);
      opB[i] = 8'hE0 + 8'(i);
    end
    allA = {opA[3], opA[2], opA[1], opA[0]};
    allB = {opB[3], opB[2], opB[1], opB[0]};

    // Reset state
    doReset;
    checkOutput("rst_req_ready", 32'(reqReady), 32'h0);
    checkOutput("rst_rsp_valid", 32'(rspValid), 32'h0);
    checkOutput("rst_rsp_sum", 32'(rspSum), 32'h0);
    checkOutput("rst_rsp_id", 32'(rspId), 32'h0);
    checkOutput("rst_txn_count", 32'(txnCount), 32'h0);

    // Single-request table: accept, one cycle in A, then result in R
    for (int v = 0; v < 7; v++) begin
      applyStimulus(4'b0001 << vecs[v].id, place(vecs[v].id, vecs[v].a),
                    place(vecs[v].id, vecs[v].b), 1'b1);
      #1;
      checkOutput($sformatf("vec%0d_ready", v), 32'(reqReady), 32'(vecs[v].ready));
      tick;
      applyStimulus(4'b0000, 32'h0, 32'h0, 1'b1);
      #1;
      checkOutput($sformatf("vec%0d_early_valid", v), 32'(rspValid), 32'h0);
      tick;
      checkOutput($sformatf("vec%0d_valid", v), 32'(rspValid), 32'h1);
      checkOutput($sformatf("vec%0d_sum", v), 32'(rspSum), 32'(vecs[v].sum));
      checkOutput($sformatf("vec%0d_id", v), 32'(rspId), 32'(vecs[v].id));
      tick;
    end
    checkOutput("drained_valid", 32'(rspValid), 32'h0);

    // Round-robin with all requesters active and no backpressure
    doReset;
    applyStimulus(4'hF, allA, allB, 1'b1);
    #1;
    for (int c = 0; c < 8; c++) begin
      checkOutput($sformatf("rr%0d_ready", c), 32'(reqReady), 32'(4'b0001 << rrSeq[c]));
      if (c >= 2) begin
        checkOutput($sformatf("rr%0d_id", c), 32'(rspId), 32'(rrSeq[c-2]));
        checkOutput($sformatf("rr%0d_sum", c), 32'(rspSum), 32'(expSum(rrSeq[c-2])));
      end
      tick;
    end

    // Backpressure: two fill the pipe, then a one-cycle drain admits one more
    doReset;
    applyStimulus(4'hF, allA, allB, 1'b0);
    #1;
    checkOutput("bp_ready0", 32'(reqReady), 32'b0001);
    tick;
    checkOutput("bp_ready1", 32'(reqReady), 32'b0010);
    checkOutput("bp_valid1", 32'(rspValid), 32'h0);
    tick;
    checkOutput("bp_full_ready", 32'(reqReady), 32'h0);
    checkOutput("bp_full_id", 32'(rspId), 32'h0);
    checkOutput("bp_full_sum", 32'(rspSum), 32'(expSum(0)));
    tick;
    checkOutput("bp_hold_ready", 32'(reqReady), 32'h0);
    checkOutput("bp_hold_valid", 32'(rspValid), 32'h1);
    checkOutput("bp_hold_id", 32'(rspId), 32'h0);
    checkOutput("bp_hold_sum", 32'(rspSum), 32'(expSum(0)));
    applyStimulus(4'hF, allA, allB, 1'b1);
    #1;
    checkOutput("bp_drain_ready", 32'(reqReady), 32'b0100);
    tick;
    applyStimulus(4'hF, allA, allB, 1'b0);
    #1;
    checkOutput("bp_refull_ready", 32'(reqReady), 32'h0);
    checkOutput("bp_r1_id", 32'(rspId), 32'h1);
    checkOutput("bp_r1_sum", 32'(rspSum), 32'(expSum(1)));
    applyStimulus(4'h0, allA, allB, 1'b1);
    tick;
    checkOutput("bp_r2_valid", 32'(rspValid), 32'h1);
    checkOutput("bp_r2_id", 32'(rspId), 32'h2);
    checkOutput("bp_r2_sum", 32'(rspSum), 32'(expSum(2)));
    tick;
    checkOutput("bp_empty_valid", 32'(rspValid), 32'h0);

    // Asynchronous reset with two transactions in flight
    doReset;
    applyStimulus(4'hF, allA, allB, 1'b0);
    tick;
    tick;
    checkOutput("mid_inflight_valid", 32'(rspValid), 32'h1);
    #2 rstN = 1'b0;
    #1;
    checkOutput("mid_async_valid", 32'(rspValid), 32'h0);
    checkOutput("mid_async_sum", 32'(rspSum), 32'h0);
    @(posedge clk);
    #3 rstN = 1'b1;
    rspReady = 1'b1;
    #1;
    checkOutput("mid_first_ready", 32'(reqReady), 32'b0001);
    tick;
    checkOutput("mid_no_stale", 32'(rspValid), 32'h0);
    checkOutput("mid_second_ready", 32'(reqReady), 32'b0010);
    tick;
    checkOutput("mid_first_valid", 32'(rspValid), 32'h1);
    checkOutput("mid_first_id", 32'(rspId), 32'h0);
    checkOutput("mid_first_sum", 32'(rspSum), 32'(expSum(0)));

`ifdef ADDER_RR_SCHED_STATS_EN
    // One accept per edge from requester 0 until well past saturation
    doReset;
    applyStimulus(4'b0001, allA, allB, 1'b1);
    repeat (100) @(posedge clk);
    #1;
    checkOutput("stats_100", 32'(txnCount), 32'd100);
    repeat (65435) @(posedge clk);
    #1;
    checkOutput("stats_65535", 32'(txnCount), 32'hFFFF);
    repeat (4465) @(posedge clk);
    #1;
    checkOutput("stats_70000", 32'(txnCount), 32'hFFFF);
`else
    checkOutput("nostats_after_traffic", 32'(txnCount), 32'h0);
    applyStimulus(4'hF, allA, allB, 1'b1);
    repeat (50) tick;
    checkOutput("nostats_after_50", 32'(txnCount), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
